inst_aligner: RTL and testbench

- Front-end stage directly upstream of the instruction decoder.
- Owns the fetch PC and issues word-aligned fetch requests to the memory/icache controller.
- Buffers returned 32-bit words as 16-bit halfwords and presents one complete instruction per handshake, either a 16-bit RVC instruction or a 32-bit instruction, each with its PC.
- Handles instructions that straddle word boundaries, and handles branch/jump redirects to halfword-aligned targets.

---
 rtl/inst_aligner_pkg.sv | 13 +
 rtl/inst_hw_buffer.sv | 60 ++++++
 rtl/inst_aligner.sv | 107 ++++++++++
 tb/tb_inst_aligner.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_aligner_pkg.sv
// Shared aligner constants: FSM state encodings and the RVC length test.
// Imported by the aligner top and its halfword buffer.
package inst_aligner_pkg;

    localparam logic [1:0] ALN_IDLE = 2'd0;
    localparam logic [1:0] ALN_WAIT = 2'd1;
    localparam logic [1:0] ALN_DROP = 2'd2;

    function automatic logic is_rvc(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/inst_hw_buffer.sv
// Four-entry halfword shift queue; entry 0 is the oldest halfword.
// Pop shifts out 0..2 entries, push appends 0..2 entries behind the survivors.
module inst_hw_buffer
    import inst_aligner_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        en,
    input  logic        clear,
    input  logic [1:0]  pop_n,
    input  logic [1:0]  push_n,
    input  logic [15:0] push_lo,
    input  logic [15:0] push_hi,
    output logic [15:0] hw0,
    output logic [15:0] hw1,
    output logic [2:0]  count
);

    logic [15:0] q     [4];
    logic [15:0] q_nxt [4];
    logic [2:0]  base;
    logic [2:0]  cnt_nxt;
    logic [1:0]  idx1;

    assign hw0 = q[0];
    assign hw1 = q[1];

    always_comb begin
        for (int i = 0; i < 4; i++) q_nxt[i] = q[i];
        case (pop_n)
            2'd1: begin
                q_nxt[0] = q[1];
                q_nxt[1] = q[2];
                q_nxt[2] = q[3];
            end
            2'd2: begin
                q_nxt[0] = q[2];
                q_nxt[1] = q[3];
            end
            default: ;
        endcase
        base = count - {1'b0, pop_n};
        idx1 = base[1:0] + 2'd1;
        if (push_n != 2'd0) q_nxt[base[1:0]] = push_lo;
        if (push_n == 2'd2) q_nxt[idx1] = push_hi;
        cnt_nxt = base + {1'b0, push_n};
        if (clear) cnt_nxt = 3'd0;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count <= 3'd0;
            for (int i = 0; i < 4; i++) q[i] <= 16'h0;
        end else if (en) begin
            count <= cnt_nxt;
            for (int i = 0; i < 4; i++) q[i] <= q_nxt[i];
        end
    end

endmodule

// File: rtl/inst_aligner.sv
// Fetch front end: owns the fetch PC, requests aligned words and hands
// one RVC or 32-bit instruction per handshake to the decoder.
module inst_aligner
    import inst_aligner_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic        fetch_req_out,
    output logic [31:0] fetch_addr_out,
    input  logic        fetch_done_in,
    input  logic [31:0] fetch_data_in,
    output logic        inst_valid_out,
    input  logic        inst_ready_in,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        is_c_out
);

    logic [1:0]  state;
    logic [31:0] head_pc;
    logic [31:0] fetch_pc;
    logic [31:0] req_addr;
    logic        skip_lo;
    logic [15:0] hw0;
    logic [15:0] hw1;
    logic [2:0]  count;
    logic        need2;
    logic        pop;
    logic        done_ok;
    logic [1:0]  pop_n;
    logic [1:0]  push_n;
    logic [15:0] push_lo;

    assign need2          = !is_rvc(hw0);
    assign inst_valid_out = need2 ? (count >= 3'd2) : (count >= 3'd1);
    assign is_c_out       = (count != 3'd0) && !need2;
    assign inst_out       = need2 ? {hw1, hw0} : {16'h0, hw0};
    assign pc_out         = head_pc;
    assign fetch_req_out  = (state == ALN_WAIT) || (state == ALN_DROP);
    assign fetch_addr_out = req_addr;

    // Redirect outranks both pop and push in the same cycle.
    assign pop     = inst_valid_out && inst_ready_in && rdy_in && !redirect_in;
    assign pop_n   = pop ? (need2 ? 2'd2 : 2'd1) : 2'd0;
    assign done_ok = rdy_in && (state == ALN_WAIT) && fetch_done_in
                     && !redirect_in;
    assign push_n  = done_ok ? (skip_lo ? 2'd1 : 2'd2) : 2'd0;
    assign push_lo = skip_lo ? fetch_data_in[31:16] : fetch_data_in[15:0];

    inst_hw_buffer u_buf (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .en       (rdy_in),
        .clear    (redirect_in),
        .pop_n    (pop_n),
        .push_n   (push_n),
        .push_lo  (push_lo),
        .push_hi  (fetch_data_in[31:16]),
        .hw0      (hw0),
        .hw1      (hw1),
        .count    (count)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= ALN_IDLE;
            head_pc  <= RESET_PC;
            fetch_pc <= RESET_PC & ~32'd3;
            skip_lo  <= RESET_PC[1];
            req_addr <= 32'h0;
        end else if (rdy_in) begin
            if (redirect_in) begin
                head_pc  <= redirect_pc_in & ~32'd1;
                fetch_pc <= redirect_pc_in & ~32'd3;
                skip_lo  <= redirect_pc_in[1];
            end else begin
                if (pop) head_pc <= head_pc + (need2 ? 32'd4 : 32'd2);
                if (done_ok) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    skip_lo  <= 1'b0;
                end
            end
            case (state)
                ALN_IDLE: begin
                    if (count <= 3'd2 && !redirect_in) begin
                        state    <= ALN_WAIT;
                        req_addr <= fetch_pc;
                    end
                end
                ALN_WAIT: begin
                    if (fetch_done_in) state <= ALN_IDLE;
                    else if (redirect_in) state <= ALN_DROP;
                end
                ALN_DROP: begin
                    if (fetch_done_in) state <= ALN_IDLE;
                end
                default: state <= ALN_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_aligner.sv
// Directed bench for inst_aligner: memory responder, handshake monitor
// and hand-computed expected instruction streams.
module tb_inst_aligner;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        fetch_req_out;
    logic [31:0] fetch_addr_out;
    logic        fetch_done_in;
    logic [31:0] fetch_data_in;
    logic        inst_valid_out;
    logic        inst_ready_in;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        is_c_out;

    logic        auto_mem;
    logic        mem_done;
    logic [31:0] mem_data;
    logic        man_done;
    logic [31:0] man_data;
    logic [31:0] mem [0:255];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        c;
    } rec_t;
    rec_t got_q[$];

    int n_chk = 0;
    int n_err = 0;

    assign fetch_done_in = auto_mem ? mem_done : man_done;
    assign fetch_data_in = auto_mem ? mem_data : man_data;

    inst_aligner #(.RESET_PC(32'h0)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .rdy_in         (rdy_in),
        .redirect_in    (redirect_in),
        .redirect_pc_in (redirect_pc_in),
        .fetch_req_out  (fetch_req_out),
        .fetch_addr_out (fetch_addr_out),
        .fetch_done_in  (fetch_done_in),
        .fetch_data_in  (fetch_data_in),
        .inst_valid_out (inst_valid_out),
        .inst_ready_in  (inst_ready_in),
        .inst_out       (inst_out),
        .pc_out         (pc_out),
        .is_c_out       (is_c_out)
    );

    always #5 clk_in = ~clk_in;

    // One-cycle-latency memory
    always @(negedge clk_in) begin
        if (auto_mem && fetch_req_out && !mem_done) begin
            mem_done = 1'b1;
            mem_data = mem[fetch_addr_out[9:2]];
        end else begin
            mem_done = 1'b0;
        end
    end

    always begin
        @(negedge clk_in);
        #2;
        if (rst_n_in && rdy_in && inst_valid_out && inst_ready_in
            && !redirect_in)
            got_q.push_back('{pc: pc_out, inst: inst_out, c: is_c_out});
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        tick();
        tick();
        rst_n_in = 1'b1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!fetch_req_out && n < 10) begin
            tick();
            n++;
        end
        chk(tag, fetch_req_out, 1);
    endtask

    task automatic pulse(input logic [31:0] d);
        man_data = d;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
    endtask

    task automatic chk_rec(input int i, input logic [31:0] pc,
                           input logic [31:0] inst, input logic c);
        if (got_q.size() <= i) begin
            chk($sformatf("rec%0d_n", i), got_q.size(), i + 1);
        end else begin
            chk($sformatf("rec%0d_pc", i), got_q[i].pc, pc);
            chk($sformatf("rec%0d_inst", i), got_q[i].inst, inst);
            chk($sformatf("rec%0d_c", i), got_q[i].c, c);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst_n_in       = 1'b0;
        rdy_in         = 1'b1;
        redirect_in    = 1'b0;
        redirect_pc_in = 32'h0;
        inst_ready_in  = 1'b1;
        auto_mem       = 1'b1;
        mem_done       = 1'b0;
        mem_data       = 32'h0;
        man_done       = 1'b0;
        man_data       = 32'h0;
        tick();

        chk("rst_valid", inst_valid_out, 0);
        chk("rst_req", fetch_req_out, 0);
        chk("rst_addr", fetch_addr_out, 0);
        chk("rst_inst", inst_out, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_c", is_c_out, 0);

        // Mixed 32-bit and RVC
        mem[0] = 32'h00A00093;
        mem[1] = 32'h45014505;
        do_reset();
        got_q.delete();
        repeat (15) tick();
        chk_rec(0, 32'h0, 32'h00A00093, 1'b0);
        chk_rec(1, 32'h4, 32'h00004505, 1'b1);
        chk_rec(2, 32'h6, 32'h00004501, 1'b1);

        // Straddling 32-bit instruction
        auto_mem = 1'b0;
        inst_ready_in = 1'b1;
        do_reset();
        wait_req("str_req0");
        chk("str_addr0", fetch_addr_out, 32'h0);
        pulse(32'h00930001);
        chk("str_v0", inst_valid_out, 1);
        chk("str_pc0", pc_out, 32'h0);
        chk("str_inst0", inst_out, 32'h00000001);
        chk("str_c0", is_c_out, 1);
        tick();
        chk("str_wait_v", inst_valid_out, 0);
        chk("str_req1", fetch_req_out, 1);
        chk("str_addr1", fetch_addr_out, 32'h4);
        pulse(32'h000000A0);
        chk("str_v1", inst_valid_out, 1);
        chk("str_pc1", pc_out, 32'h2);
        chk("str_inst1", inst_out, 32'h00A00093);
        chk("str_c1", is_c_out, 0);

        // Redirect to halfword-aligned target
        inst_ready_in = 1'b0;
        do_reset();
        redirect_in = 1'b1;
        redirect_pc_in = 32'h102;
        tick();
        redirect_in = 1'b0;
        chk("rd_v", inst_valid_out, 0);
        wait_req("rd_req");
        chk("rd_addr", fetch_addr_out, 32'h100);
        pulse(32'h4505ABCD);
        chk("rd_valid", inst_valid_out, 1);
        chk("rd_pc", pc_out, 32'h102);
        chk("rd_inst", inst_out, 32'h00004505);
        chk("rd_c", is_c_out, 1);

        // Redirect while a fetch is outstanding
        tick();
        chk("wt_req", fetch_req_out, 1);
        chk("wt_addr", fetch_addr_out, 32'h104);
        redirect_in = 1'b1;
        redirect_pc_in = 32'h200;
        tick();
        redirect_in = 1'b0;
        chk("drop_v", inst_valid_out, 0);
        chk("drop_req", fetch_req_out, 1);
        chk("drop_addr", fetch_addr_out, 32'h104);
        tick();
        pulse(32'hDEADBEEF);
        chk("drop_disc_v", inst_valid_out, 0);
        chk("drop_idle", fetch_req_out, 0);
        tick();
        chk("new_req", fetch_req_out, 1);
        chk("new_addr", fetch_addr_out, 32'h200);
        redirect_in = 1'b1;
        redirect_pc_in = 32'h300;
        pulse(32'hDEADBEEF);
        redirect_in = 1'b0;
        chk("same_idle", fetch_req_out, 0);
        chk("same_v", inst_valid_out, 0);
        tick();
        chk("same_req", fetch_req_out, 1);
        chk("same_addr", fetch_addr_out, 32'h300);

        // Backpressure with an RVC stream
        mem[0] = 32'h00050001;
        mem[1] = 32'h000D0009;
        mem[2] = 32'h00150011;
        mem[3] = 32'h001D0019;
        auto_mem = 1'b1;
        inst_ready_in = 1'b0;
        do_reset();
        repeat (12) tick();
        chk("bp_count", dut.u_buf.count, 4);
        chk("bp_req", fetch_req_out, 0);
        chk("bp_pc", pc_out, 32'h0);
        chk("bp_inst", inst_out, 32'h1);
        repeat (3) tick();
        chk("bp_req2", fetch_req_out, 0);
        chk("bp_pc2", pc_out, 32'h0);
        chk("bp_inst2", inst_out, 32'h1);
        got_q.delete();
        inst_ready_in = 1'b1;
        repeat (20) tick();
        chk_rec(0, 32'h0, 32'h00000001, 1'b1);
        chk_rec(1, 32'h2, 32'h00000005, 1'b1);
        chk_rec(2, 32'h4, 32'h00000009, 1'b1);
        chk_rec(3, 32'h6, 32'h0000000D, 1'b1);
        chk_rec(4, 32'h8, 32'h00000011, 1'b1);
        chk_rec(5, 32'hA, 32'h00000015, 1'b1);

        // Async reset mid-WAIT
        auto_mem = 1'b0;
        inst_ready_in = 1'b0;
        do_reset();
        redirect_in = 1'b1;
        redirect_pc_in = 32'h40;
        tick();
        redirect_in = 1'b0;
        wait_req("ar_req");
        chk("ar_addr", fetch_addr_out, 32'h40);
        rst_n_in = 1'b0;
        #1;
        chk("ar_req0", fetch_req_out, 0);
        chk("ar_addr0", fetch_addr_out, 32'h0);
        chk("ar_pc0", pc_out, 32'h0);
        tick();
        rst_n_in = 1'b1;
        tick();
        chk("ar_req1", fetch_req_out, 1);
        chk("ar_addr1", fetch_addr_out, 32'h0);

        // rdy_in low freezes everything
        pulse(32'h00050001);
        chk("frz_v", inst_valid_out, 1);
        inst_ready_in = 1'b1;
        rdy_in = 1'b0;
        got_q.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("frz_pc%0d", i), pc_out, 32'h0);
            chk($sformatf("frz_inst%0d", i), inst_out, 32'h1);
        end
        chk("frz_req", fetch_req_out, 0);
        chk("frz_nopop", got_q.size(), 0);
        rdy_in = 1'b1;
        tick();
        chk("frz_rel_pc", pc_out, 32'h2);
        chk("frz_rel_inst", inst_out, 32'h5);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
